// File: rtl/spi_cycle_bridge_pkg.sv
// Shared definitions for the punted-cycle SPI bridge: frame layout and FSM encoding.
// Frame on the wire is {RW, A[22:0], D[31:24]}, MSB first.
package spi_cycle_bridge_pkg;

  localparam int FRAME_BITS = 32;
  localparam int RW_BIT     = 31;
  localparam int ADDR_HI    = 30;
  localparam int ADDR_LO    = 8;
  localparam int WDATA_HI   = 7;
  localparam int WDATA_LO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic rw,
                                                       input logic [22:0] addr,
                                                       input logic [7:0] wdata);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[RW_BIT]              = rw;
    f[ADDR_HI:ADDR_LO]     = addr;
    f[WDATA_HI:WDATA_LO]   = wdata;
    return f;
  endfunction

endpackage

// File: rtl/spi_cycle_bridge_sync_edge.sv
// Multi-flop synchroniser with rise/fall detect on the last two synchronised samples.
// Edge pulses appear STAGES cycles after the pin changes; no backpressure.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_cycle_bridge.sv
// Latches one punted CPU cycle, serialises it to the MCU as SPI slave, returns the read byte and ACK.
// ACK/DOE/DOUT follow NSS rise by SYNC_STAGES+1 cycles; AS20 high aborts or releases in 1 cycle.
module spi_cycle_bridge
  import spi_cycle_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLKCPU_A,
  input  logic        RESET_N,
  input  logic        CYCLE_REQ,
  input  logic        AS20,
  input  logic        RW,
  input  logic [22:0] A,
  input  logic [7:0]  DIN,
  input  logic        SPI_CK,
  input  logic        SPI_MOSI,
  input  logic        SPI_NSS,
  output logic        SPI_MISO,
  output logic [7:0]  DOUT,
  output logic        DOE,
  output logic        ACK,
  output logic        FRAME_ERR,
  output logic        BUSY
);

  state_t                state;
  logic [FRAME_BITS-1:0] tx;
  logic [FRAME_BITS-1:0] tx_hold;
  logic [7:0]            rx;
  logic [5:0]            bit_cnt;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                  mosi_s;
  logic                  sck_rise, sck_fall;
  logic                  nss_rise, nss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk   (CLKCPU_A),
    .rst_n (RESET_N),
    .d     (SPI_CK),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // NSS idles high, so its synchroniser resets high to avoid a false fall.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nss_sync (
    .clk   (CLKCPU_A),
    .rst_n (RESET_N),
    .d     (SPI_NSS),
    .rise  (nss_rise),
    .fall  (nss_fall)
  );

  // MOSI goes through the same depth as SCK so the sample lines up with the detected rise.
  always_ff @(posedge CLKCPU_A or negedge RESET_N) begin
    if (!RESET_N) mosi_sync <= '0;
    else          mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge CLKCPU_A or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      tx        <= '0;
      tx_hold   <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      DOUT      <= 8'h00;
      DOE       <= 1'b0;
      ACK       <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (CYCLE_REQ) begin
            tx      <= pack_frame(RW, A, DIN);
            tx_hold <= pack_frame(RW, A, DIN);
            bit_cnt <= '0;
            state   <= ST_LOADED;
          end
        end
        ST_LOADED: begin
          if (AS20) begin
            state <= ST_IDLE;
          end else if (nss_fall) begin
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (AS20) begin
            state <= ST_IDLE;
          end else if (nss_rise) begin
            if (bit_cnt == 6'(FRAME_BITS)) begin
              DOUT  <= rx;
              DOE   <= tx_hold[RW_BIT];
              ACK   <= 1'b1;
              state <= ST_DONE;
            end else begin
              // Malformed frame: rewind so the MCU can simply retry the transfer.
              FRAME_ERR <= 1'b1;
              tx        <= tx_hold;
              bit_cnt   <= '0;
              state     <= ST_LOADED;
            end
          end else begin
            if (sck_rise) begin
              rx <= {rx[6:0], mosi_s};
              if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
            end
            if (sck_fall) tx <= {tx[FRAME_BITS-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          if (AS20) begin
            DOE   <= 1'b0;
            ACK   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // SHIFT is exactly the window where NSS is low for this cycle, so MISO is gated on it.
  assign SPI_MISO = (state == ST_SHIFT) & tx[FRAME_BITS-1];
  assign BUSY     = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_cycle_bridge.sv
// Bench for spi_cycle_bridge: table-driven SPI frames plus hand sequences for retry, abort, overlap and reset.
module tb_spi_cycle_bridge;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cycle_req;
  logic        as20;
  logic        rw;
  logic [22:0] a;
  logic [7:0]  din;
  logic        sck, mosi, nss;
  logic        miso;
  logic [7:0]  dout;
  logic        doe, ack, ferr, busy;

  always #5 clk = ~clk;

  spi_cycle_bridge #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLKCPU_A  (clk),
    .RESET_N   (rst_n),
    .CYCLE_REQ (cycle_req),
    .AS20      (as20),
    .RW        (rw),
    .A         (a),
    .DIN       (din),
    .SPI_CK    (sck),
    .SPI_MOSI  (mosi),
    .SPI_NSS   (nss),
    .SPI_MISO  (miso),
    .DOUT      (dout),
    .DOE       (doe),
    .ACK       (ack),
    .FRAME_ERR (ferr),
    .BUSY      (busy)
  );

  typedef struct {
    logic       rw;
    logic [22:0] a;
    logic [7:0]  din;
    logic [31:0] mcu;
    logic [31:0] exp_miso;
    logic [7:0]  exp_dout;
    logic        exp_doe;
  } vec_t;

  typedef struct {
    logic       ack;
    logic       doe;
    logic [7:0] dout;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  vec_t vt[4];

  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;
  int ack_rises = 0;
  logic ack_d = 1'b0;

  always @(negedge clk) begin
    if (ferr === 1'b1) ferr_cnt++;
    if (ack === 1'b1 && ack_d !== 1'b1) ack_rises++;
    ack_d = ack;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [31:0] word, input int nbits, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[31-i];
      tick(4);
      got  = {got[30:0], miso};
      sck  = 1'b1;
      tick(4);
      sck  = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic nss_low();
    nss = 1'b0;
    tick(6);
  endtask

  task automatic nss_high();
    tick(4);
    nss = 1'b1;
  endtask

  task automatic start_cycle(input logic r, input logic [22:0] ad, input logic [7:0] d, input string tag);
    rw        = r;
    a         = ad;
    din       = d;
    as20      = 1'b0;
    cycle_req = 1'b1;
    tick();
    cycle_req = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic await_result(input string tag);
    exp_t e;
    bit   seen;
    int   n;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (ack === 1'b1 || ferr === 1'b1) seen = 1'b1;
    end
    check({tag, "_response"}, 32'(seen), 32'd1);
    check({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(n), 32'(SYNC_STAGES + 1));
      check({tag, "_ack"}, 32'(ack), 32'(e.ack));
      check({tag, "_ferr"}, 32'(ferr), 32'(e.ferr));
      check({tag, "_doe"}, 32'(doe), 32'(e.doe));
      if (e.ack) check({tag, "_dout"}, 32'(dout), 32'(e.dout));
    end
  endtask

  task automatic release_cycle(input string tag, input int rises_before);
    as20 = 1'b1;
    tick();
    check({tag, "_rel_ack"}, 32'(ack), 32'd0);
    check({tag, "_rel_doe"}, 32'(doe), 32'd0);
    check({tag, "_rel_busy"}, 32'(busy), 32'd0);
    check({tag, "_ack_once"}, 32'(ack_rises), 32'(rises_before + 1));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] got;
    int          r0;
    r0 = ack_rises;
    start_cycle(v.rw, v.a, v.din, tag);
    check({tag, "_miso_nss_high"}, 32'(miso), 32'd0);
    sb.push_back('{ack: 1'b1, doe: v.exp_doe, dout: v.exp_dout, ferr: 1'b0});
    nss_low();
    spi_bits(v.mcu, 32, got);
    check({tag, "_miso_word"}, got, v.exp_miso);
    nss_high();
    await_result(tag);
    tick(5);
    check({tag, "_ack_hold"}, 32'(ack), 32'd1);
    check({tag, "_doe_hold"}, 32'(doe), 32'(v.exp_doe));
    release_cycle(tag, r0);
  endtask

  initial begin
    logic [31:0] got, g1, g2;
    int f0, r0;

    vt[0] = '{rw: 1'b1, a: 23'h5C0034, din: 8'h77, mcu: 32'h000000A5,
              exp_miso: 32'hDC003477, exp_dout: 8'hA5, exp_doe: 1'b1};
    vt[1] = '{rw: 1'b0, a: 23'h3FE000, din: 8'h3C, mcu: 32'h00000000,
              exp_miso: 32'h3FE0003C, exp_dout: 8'h00, exp_doe: 1'b0};
    vt[2] = '{rw: 1'b1, a: 23'h000001, din: 8'h00, mcu: 32'h0000005A,
              exp_miso: 32'h80000100, exp_dout: 8'h5A, exp_doe: 1'b1};
    vt[3] = '{rw: 1'b1, a: 23'h7FFFFF, din: 8'hC3, mcu: 32'hDEADBEFF,
              exp_miso: 32'hFFFFFFC3, exp_dout: 8'hFF, exp_doe: 1'b1};

    rst_n = 1'b0; cycle_req = 1'b0; as20 = 1'b1; rw = 1'b0; a = '0; din = '0;
    sck = 1'b0; mosi = 1'b0; nss = 1'b1;
    tick(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_doe", 32'(doe), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 4; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Short frame then a full retry of the same cycle.
    r0 = ack_rises;
    f0 = ferr_cnt;
    start_cycle(1'b1, 23'h123456, 8'h00, "short");
    sb.push_back('{ack: 1'b0, doe: 1'b0, dout: 8'h00, ferr: 1'b1});
    nss_low();
    spi_bits(32'h000000C7, 31, got);
    check("short_miso_31", got, 32'h491A2B00);
    nss_high();
    await_result("short");
    check("short_busy_loaded", 32'(busy), 32'd1);
    tick();
    check("short_ferr_one_pulse", 32'(ferr), 32'd0);
    tick(3);
    check("short_ferr_count", 32'(ferr_cnt), 32'(f0 + 1));
    sb.push_back('{ack: 1'b1, doe: 1'b1, dout: 8'hC7, ferr: 1'b0});
    nss_low();
    spi_bits(32'h000000C7, 32, got);
    check("retry_miso_word", got, 32'h92345600);
    nss_high();
    await_result("retry");
    release_cycle("retry", r0);

    // Abort after 10 SCKs.
    r0 = ack_rises;
    f0 = ferr_cnt;
    start_cycle(1'b0, 23'h0ABCDE, 8'h11, "abort");
    nss_low();
    spi_bits(32'hFFFFFFFF, 10, got);
    as20 = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    nss = 1'b1;
    tick(6);
    check("abort_no_ferr", 32'(ferr_cnt), 32'(f0));
    check("abort_no_ack", 32'(ack_rises), 32'(r0));
    check("abort_miso_idle", 32'(miso), 32'd0);
    run_vec('{rw: 1'b0, a: 23'h0ABCDE, din: 8'h11, mcu: 32'h00000000,
              exp_miso: 32'h0ABCDE11, exp_dout: 8'h00, exp_doe: 1'b0}, "after_abort");

    // Second CYCLE_REQ during SHIFT must not disturb the frame in flight.
    r0 = ack_rises;
    start_cycle(1'b1, 23'h2AAAAA, 8'h5A, "ovl");
    sb.push_back('{ack: 1'b1, doe: 1'b1, dout: 8'h96, ferr: 1'b0});
    nss_low();
    spi_bits(32'h00000096, 8, g1);
    rw = 1'b0; a = 23'h000000; din = 8'hFF; cycle_req = 1'b1;
    tick();
    cycle_req = 1'b0;
    spi_bits(32'h00009600, 24, g2);
    check("ovl_miso_word", {g1[7:0], g2[23:0]}, 32'hAAAAAA5A);
    nss_high();
    await_result("ovl");
    release_cycle("ovl", r0);

    // Reset in the middle of SHIFT clears everything asynchronously.
    start_cycle(1'b1, 23'h7FFFFF, 8'hFF, "midrst");
    nss_low();
    spi_bits(32'h00000000, 5, got);
    check("midrst_pre_miso", 32'(miso), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_dout", 32'(dout), 32'h00);
    check("midrst_doe", 32'(doe), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_ferr", 32'(ferr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    nss = 1'b1;
    as20 = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    run_vec(vt[0], "post_rst");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
